// File: rtl/avs_pkg.sv
// Shared types for the event capture path.
// Sample width, capture FSM states and counter widths.
package avs_pkg;

    localparam int DATA_W = 16;
    localparam int MISS_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        FILL,
        ARMED,
        CAPTURE,
        DRAIN
    } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port history RAM.
// Synchronous write, synchronous registered read.
module capture_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // store the incoming sample
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // one-cycle read latency
    always_ff @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/event_capture_buffer.sv
// Rolling sample history that freezes a window around a detected
// event and drains it through a valid/ready port.
module event_capture_buffer #(
    parameter int DATA_W = avs_pkg::DATA_W,
    parameter int PRE    = 4,
    parameter int POST   = 3,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] stream,
    input  logic              eventDetected,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        missed_events
);

    import avs_pkg::*;

    localparam int W  = PRE + 1 + POST;
    localparam int CW = $clog2(W + 1);

    if ((1 << ADDR_W) < W) begin : g_depth_check
        $error("ring too small for PRE+1+POST");
    end

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     fill_cnt;
    logic [CW-1:0]     post_cnt;
    logic [CW-1:0]     rd_cnt;
    logic [MISS_W-1:0] missed;

    logic              pend;
    logic              pend_last;
    logic [DATA_W-1:0] rd_data;
    logic              skid_valid;
    logic              skid_last;
    logic [DATA_W-1:0] skid_data;

    logic              wr_en;
    logic              rd_en;
    logic              pop;
    logic              room;
    logic [1:0]        lvl;

    assign missed_events = missed;
    assign pop   = out_valid && out_ready;
    assign wr_en = !reset && (state != DRAIN);

    // issue a read only if the two-entry output buffer can absorb it
    always_comb begin
        lvl   = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pend};
        room  = (lvl <= ({1'b0, pop} + 2'd1));
        rd_en = (state == DRAIN) && (rd_cnt != CW'(W)) && room;
    end

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (stream),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // capture FSM, pointers and missed-event counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            wr_ptr    <= '0;
            trig_ptr  <= '0;
            rd_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            missed    <= '0;
            busy      <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= rd_en;
            pend_last <= rd_en && (rd_cnt == CW'(W - 1));
            if (eventDetected && (state != ARMED) && (missed != '1))
                missed <= missed + MISS_W'(1);
            unique case (state)
                FILL: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fill_cnt <= fill_cnt + 1'b1;
                    if (int'(fill_cnt) + 1 >= PRE) state <= ARMED;
                end
                ARMED: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (eventDetected) begin
                        trig_ptr <= wr_ptr;
                        post_cnt <= CW'(POST);
                        rd_ptr   <= wr_ptr - ADDR_W'(PRE);
                        rd_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= (POST == 0) ? DRAIN : CAPTURE;
                    end
                end
                CAPTURE: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == CW'(1)) begin
                        rd_ptr <= trig_ptr - ADDR_W'(PRE);
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (pop && out_last) begin
                        fill_cnt <= '0;
                        rd_cnt   <= '0;
                        busy     <= 1'b0;
                        state    <= (PRE == 0) ? ARMED : FILL;
                    end
                end
            endcase
        end
    end

    // output register plus skid slot covering the RAM read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= pend;
                skid_data  <= rd_data;
                skid_last  <= pend_last;
            end else if (pend) begin
                out_data <= rd_data;
                out_last <= pend_last;
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (pend) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_last  <= pend_last;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= pend_last;
            end
        end
    end

endmodule

// File: tb/tb_event_capture_buffer.sv
// Directed bench for event_capture_buffer.
// Ramp stimulus, hand-computed windows, handshake monitor.
module tb_event_capture_buffer;

    logic        clock;
    logic        reset;
    logic [15:0] stream;
    logic        eventDetected;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [7:0]  missed_events;

    int n_chk;
    int n_fail;
    int smp;
    int ev_a;
    int ev_b;
    int ev_from;
    bit bp_mode;
    int bp_idx;
    int cyc;
    bit bp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [15:0] qd [$];
    bit          ql [$];
    int          qt [$];

    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    event_capture_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .stream        (stream),
        .eventDetected (eventDetected),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .missed_events (missed_events)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // collect accepted words and check held words stay put
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                qd.push_back(out_data);
                ql.push_back(out_last);
                qt.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic drive();
        stream        = 16'(smp);
        eventDetected = (smp == ev_a) || (smp == ev_b) ||
                        (ev_from != 0 && smp >= ev_from);
        out_ready     = bp_mode ? bp[bp_idx % 6] : 1'b1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        smp++;
        bp_idx++;
        drive();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        stream        = '0;
        eventDetected = 1'b0;
        out_ready     = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        smp    = 1;
        bp_idx = 0;
        qd.delete();
        ql.delete();
        qt.delete();
        drive();
    endtask

    task automatic check_window(string tag, int base, int idx, bit exact);
        if (exact) chk({tag, "_count"}, 32'(qd.size()), 32'(idx + 8));
        else chk({tag, "_count"}, 32'(qd.size() >= idx + 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (idx + i < qd.size()) begin
                chk({tag, "_data"}, 32'(qd[idx+i]), 32'(base + i));
                chk({tag, "_last"}, 32'(ql[idx+i]), 32'(i == 7));
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        clock = 1'b0;
        reset = 1'b1;
        stream = '0;
        eventDetected = 1'b0;
        out_ready = 1'b0;
        smp = 0;
        ev_a = 0;
        ev_b = 0;
        ev_from = 0;
        bp_mode = 1'b0;
        bp_idx = 0;
        prev_stall = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_missed", 32'(missed_events), 32'd0);

        // ramp, event on 10, ready high: window 6..13
        ev_a = 10; ev_b = 0; ev_from = 0; bp_mode = 0;
        do_reset();
        run(10);
        chk("ramp_busy", 32'(busy), 32'd1);
        run(20);
        check_window("ramp", 6, 0, 1);
        if (qt.size() == 8)
            chk("ramp_nobubble", 32'(qt[7] - qt[0]), 32'd7);
        chk("ramp_missed", 32'(missed_events), 32'd0);
        chk("ramp_idle", 32'(busy), 32'd0);

        // early event in FILL, later event on 12: window 8..15
        ev_a = 2; ev_b = 12;
        do_reset();
        run(35);
        check_window("early", 8, 0, 1);
        chk("early_missed", 32'(missed_events), 32'd1);

        // event on the last FILL edge ignored, armed from next edge
        ev_a = 4; ev_b = 6;
        do_reset();
        run(30);
        check_window("edge", 2, 0, 1);
        chk("edge_missed", 32'(missed_events), 32'd1);

        // backpressure pattern 1,0,0,1,0,1
        ev_a = 10; ev_b = 0; bp_mode = 1;
        do_reset();
        run(50);
        check_window("bp", 6, 0, 1);
        chk("bp_valid_end", 32'(out_valid), 32'd0);
        bp_mode = 0;

        // trigger pointer wraps the ring
        ev_a = 21;
        do_reset();
        run(40);
        check_window("wrap", 17, 0, 1);

        // event held high from sample 5
        ev_a = 0; ev_from = 5;
        do_reset();
        run(40);
        check_window("cont1", 1, 0, 0);
        check_window("cont2", 19, 8, 0);
        run(300);
        chk("cont_sat", 32'(missed_events), 32'd255);
        ev_from = 0;

        // reset after the third accepted word
        ev_a = 10; ev_b = 2;
        do_reset();
        for (int i = 0; i < 40 && qd.size() < 3; i++) step();
        chk("mid_words", 32'(qd.size() >= 3), 32'd1);
        chk("mid_missed_pre", 32'(missed_events), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_last", 32'(out_last), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_missed", 32'(missed_events), 32'd0);
        reset  = 1'b0;
        smp    = 1;
        bp_idx = 0;
        qd.delete();
        ql.delete();
        qt.delete();
        drive();
        run(30);
        check_window("after", 6, 0, 1);
        chk("after_missed", 32'(missed_events), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
